// File: rtl/traffic_sched.sv
// traffic_sched: game-flow FSM (IDLE/RUN/PAUSE/OVER, level, lives) plus a
// level-paced movement tick fanned out as staggered per-lane move strobes.
module traffic_sched #(
   parameter int unsigned C_LANES     = 4,
   parameter int unsigned C_LIVES     = 3,
   parameter int unsigned C_SIM_SHIFT = 0
) (
   input  logic               i_Clk,
   input  logic               i_Rst_n,
   input  logic               i_Start,
   input  logic               i_Pause,
   input  logic               i_Level_Up,
   input  logic               i_Collision,
   output logic [3:0]         o_Level,
   output logic [2:0]         o_Lives,
   output logic [1:0]         o_State,
   output logic [C_LANES-1:0] o_Lane_En,
   output logic [C_LANES-1:0] o_Move,
   output logic               o_Tick
);

   localparam int unsigned C_IDX_W = (C_LANES > 1) ? $clog2(C_LANES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   state_t              r_State;
   state_t              w_State_Nxt;
   logic [3:0]          r_Level;
   logic [2:0]          r_Lives;
   logic [16:0]         r_Cnt;
   logic                r_Sw_Act;
   logic [C_IDX_W-1:0]  r_Sw_Idx;
   logic [C_LANES-1:0]  r_Move;
   logic                r_Tick;

   logic                w_Restart;
   logic                w_Dec_Life;
   logic                w_Lvl_Inc;
   logic                w_Advance;
   logic [16:0]         w_P;
   logic [16:0]         w_Ps;
   logic [16:0]         w_Pe;
   logic [C_LANES-1:0]  w_Lane_En;
   logic [C_LANES-1:0]  w_Lane_Sel;

   // Level-dependent tick period, scaled and floored so a sweep always fits.
   always_comb begin
      w_P = 17'd80000;
      case (r_Level)
         4'd1:    w_P = 17'd80000;
         4'd2:    w_P = 17'd70000;
         4'd3:    w_P = 17'd60000;
         4'd4:    w_P = 17'd50000;
         4'd5:    w_P = 17'd45000;
         4'd6:    w_P = 17'd40000;
         4'd7:    w_P = 17'd32000;
         4'd8:    w_P = 17'd30000;
         4'd9:    w_P = 17'd15000;
         default: w_P = 17'd80000;
      endcase
      w_Ps = w_P >> C_SIM_SHIFT;
      w_Pe = (w_Ps < 17'(C_LANES)) ? 17'(C_LANES) : w_Ps;
   end

   // Active-lane mask and one-hot decode of the current sweep slot.
   always_comb begin
      w_Lane_En  = '0;
      w_Lane_Sel = '0;
      for (int unsigned k = 0; k < C_LANES; k++) begin
         w_Lane_En[k]  = (32'(r_Level) > k);
         w_Lane_Sel[k] = (32'(r_Sw_Idx) == k);
      end
   end

   // Game state register.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_State <= ST_IDLE;
      end else begin
         r_State <= w_State_Nxt;
      end
   end

   // Next state and datapath control. Counter and sweep only step on cycles
   // that stay in RUN, so pause entry/exit and game-over edges emit nothing.
   always_comb begin
      w_State_Nxt = r_State;
      w_Restart   = 1'b0;
      w_Dec_Life  = 1'b0;
      w_Lvl_Inc   = 1'b0;
      w_Advance   = 1'b0;
      case (r_State)
         ST_IDLE, ST_OVER: begin
            if (i_Start) begin
               w_State_Nxt = ST_RUN;
               w_Restart   = 1'b1;
            end
         end
         ST_RUN: begin
            if (i_Collision) begin
               w_Dec_Life = 1'b1;
               if (r_Lives <= 3'd1) begin
                  w_State_Nxt = ST_OVER;
               end else if (i_Pause) begin
                  w_State_Nxt = ST_PAUSE;
               end else begin
                  w_Advance = 1'b1;
               end
            end else begin
               w_Lvl_Inc = i_Level_Up;
               if (i_Pause) begin
                  w_State_Nxt = ST_PAUSE;
               end else if (!i_Level_Up) begin
                  w_Advance = 1'b1;
               end
            end
         end
         ST_PAUSE: begin
            if (i_Pause) begin
               w_State_Nxt = ST_RUN;
            end
         end
         default: w_State_Nxt = ST_IDLE;
      endcase
   end

   // Level, lives, period counter and lane sweep.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Level  <= 4'd1;
         r_Lives  <= 3'(C_LIVES);
         r_Cnt    <= '0;
         r_Sw_Act <= 1'b0;
         r_Sw_Idx <= '0;
         r_Move   <= '0;
         r_Tick   <= 1'b0;
      end else begin
         r_Move <= '0;
         r_Tick <= 1'b0;
         if (w_Restart) begin
            r_Level  <= 4'd1;
            r_Lives  <= 3'(C_LIVES);
            r_Cnt    <= '0;
            r_Sw_Act <= 1'b0;
            r_Sw_Idx <= '0;
         end else begin
            if (w_Dec_Life) begin
               r_Lives <= r_Lives - 3'd1;
            end
            if (w_Lvl_Inc) begin
               if (r_Level < 4'd9) begin
                  r_Level <= r_Level + 4'd1;
               end
               r_Cnt    <= '0;
               r_Sw_Act <= 1'b0;
               r_Sw_Idx <= '0;
            end else if (w_Advance) begin
               if (r_Sw_Act) begin
                  r_Move <= w_Lane_Sel & w_Lane_En;
                  if (32'(r_Sw_Idx) == C_LANES - 1) begin
                     r_Sw_Act <= 1'b0;
                  end else begin
                     r_Sw_Idx <= r_Sw_Idx + C_IDX_W'(1);
                  end
               end
               // The wrap arms the next sweep; it cannot coincide with an
               // active one because the period is floored at C_LANES.
               if (r_Cnt == w_Pe) begin
                  r_Cnt    <= '0;
                  r_Tick   <= 1'b1;
                  r_Sw_Act <= 1'b1;
                  r_Sw_Idx <= '0;
               end else begin
                  r_Cnt <= r_Cnt + 17'd1;
               end
            end
         end
      end
   end

   assign o_Level   = r_Level;
   assign o_Lives   = r_Lives;
   assign o_State   = r_State;
   assign o_Lane_En = w_Lane_En;
   assign o_Move    = r_Move;
   assign o_Tick    = r_Tick;

endmodule

// File: doc/traffic_sched.md
Name: traffic_sched

Overview:
- Central game-flow and movement scheduler for the road section.
- Owns the current level, the lives count and the IDLE/RUN/PAUSE/OVER game state.
- Generates one shared, level-dependent movement tick and delivers it as staggered one-cycle move strobes, one lane per cycle, to all active car lanes.
- Sits between the input/collision logic and the per-lane car position blocks; lanes move only on their strobe.

Parameters:
- C_LANES, 4, number of car lanes served (1..8).
- C_LIVES, 3, lives loaded on start (1..7).
- C_SIM_SHIFT, 0, right-shift applied to every tick period; set to 8 or more in simulation only.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Start  in  1  start/restart pulse.
- i_Pause  in  1  pause toggle pulse.
- i_Level_Up  in  1  pulse: player reached the goal row.
- i_Collision  in  1  pulse: player hit by a car.
- o_Level  out  4  current level, 1..9.
- o_Lives  out  3  remaining lives.
- o_State  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
- o_Lane_En  out  C_LANES  active-lane mask.
- o_Move  out  C_LANES  one-hot, one-cycle move strobe per lane.
- o_Tick  out  1  one-cycle pulse at each period wrap.

Behaviour:
- Reset (async assert, sync release): state IDLE, o_Level=1, o_Lives=C_LIVES, counter=0, sweep idle, o_Move=0, o_Tick=0. o_Lane_En is the level-1 mask (see below).
- Period table P(level), indexed on o_Level:
  - 1: 80000, 2: 70000, 3: 60000, 4: 50000, 5: 45000, 6: 40000, 7: 32000, 8: 30000, 9: 15000.
  - Any other level value uses 80000.
  - Effective period Pe = P >> C_SIM_SHIFT, floored at C_LANES.
- Counter: 17 bits.
  - Increments only in RUN.
  - At counter==Pe it wraps to 0 and o_Tick=1 for that cycle, so a tick occurs every Pe+1 cycles.
- Sweep:
  - The cycle after o_Tick, lane index k runs 0..C_LANES-1, one lane per cycle.
  - o_Move[k]=o_Lane_En[k]; inactive lanes consume their slot with no strobe.
  - A sweep always completes in C_LANES RUN cycles, and Pe≥C_LANES guarantees sweeps never overlap.
- Lane mask: lanes 0..min(o_Level, C_LANES)-1 are enabled; the rest are 0. The mask updates in the same cycle as o_Level.
- FSM:
  - IDLE: i_Start -> RUN.
  - RUN: i_Pause -> PAUSE. i_Collision -> o_Lives-1; if o_Lives was 1 -> OVER with o_Lives=0.
  - RUN, i_Level_Up: o_Level+1 (saturates at 9), counter cleared to 0, any in-progress sweep aborted. This applies in the same cycle when the level is already 9.
  - PAUSE: counter and sweep index frozen; o_Move=0 and o_Tick=0 while paused. i_Pause -> RUN, resuming exactly where it stopped. i_Start in PAUSE is ignored.
  - OVER: everything frozen, o_Move=0. i_Start -> RUN with o_Level=1, o_Lives=C_LIVES, counter=0, sweep idle.
  - i_Start while in RUN is ignored.
- Simultaneous events in RUN, in priority order:
  - i_Collision over i_Level_Up: level-up is dropped.
  - i_Pause is evaluated together with collision: the lives change applies and the state goes to PAUSE, unless lives reach 0, in which case the state goes to OVER.
- Inputs are single-cycle pulses already synchronous to i_Clk. A held level counts once per cycle; edge detection is the caller's job.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset mid-sweep or mid-pause returns to the reset values immediately; no strobe is emitted after reset asserts.

Test Plan:
- Reset, C_SIM_SHIFT=8, C_LANES=4, pulse i_Start -> o_State=01. First o_Tick comes 313 cycles after RUN entry (Pe=312). o_Move=0001 the next cycle; lanes 1..3 get no strobe at level 1 (o_Lane_En=0001).
- Three i_Level_Up pulses -> o_Level=4, o_Lane_En=1111, Pe=195. The sweep strobes 0001,0010,0100,1000 on 4 consecutive cycles after each tick. A level-up mid-sweep aborts the remaining strobes.
- Twelve i_Level_Up pulses -> o_Level saturates at 9, Pe=58. Check tick spacing is 59 cycles.
- i_Pause mid-sweep at k=2 and hold 50 cycles, then i_Pause -> no strobes while paused. The next strobe is o_Move=0100, and the counter resumes from its frozen value.
- Three i_Collision pulses -> o_Lives 3,2,1, then o_State=OVER with o_Lives=0. i_Collision and i_Level_Up in the same cycle -> level unchanged. i_Start from OVER -> RUN, level 1, lives 3.
- Assert i_Rst_n=0 asynchronously mid-sweep in RUN at level 5 -> outputs go to the reset values without waiting for a clock edge, o_Move=0.
